chime_scheduler: RTL



---
 rtl/chime_pkg.sv | 11 +
 rtl/bcd_hour_count.sv | 26 ++
 rtl/chime_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/chime_pkg.sv
// Shared types and constants for the chime/alarm audio scheduler.
package chime_pkg;
  typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF} state_t;
  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_CHIME = 2'b01,
    SRC_ALARM = 2'b10
  } src_t;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [4:0] HALF_DAY = 5'd12;
endpackage

// File: rtl/bcd_hour_count.sv
// Validates the BCD hour digits and converts them to a chime ring count.
module bcd_hour_count
  import chime_pkg::*;
#(
  parameter bit TWELVE_HOUR = 1'b1
) (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       valid,
  output logic [4:0] count
);
  logic [4:0] hour;

  always_comb begin
    // only meaningful when the digits are in range; checked in valid below
    hour = 5'(tens[1:0]) * 5'd10 + {1'b0, ones};
    if (TWELVE_HOUR) begin
      if (hour == 5'd0)          count = HALF_DAY;
      else if (hour > HALF_DAY)  count = hour - HALF_DAY;
      else                       count = hour;
    end else begin
      count = hour;
    end
    valid = (tens <= 4'd2) && (ones <= 4'd9) && (hour <= HOUR_MAX) && (count != 5'd0);
  end
endmodule

// File: rtl/chime_scheduler.sv
// Arbitrates the buzzer between the hourly chime and the alarm; beep timing
// counts slow tick enables. Alarm preempts chime, which resumes afterwards.
module chime_scheduler
  import chime_pkg::*;
#(
  parameter int ON_TICKS    = 5,
  parameter int OFF_TICKS   = 5,
  parameter int ALARM_BEEPS = 30,
  parameter bit TWELVE_HOUR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        on_the_hour,
  input  logic        on_alarm,
  input  logic        alarm_stop,
  input  logic [23:0] clock_time,
  output logic        audio,
  output logic        busy,
  output logic [1:0]  src,
  output logic [5:0]  beeps_left
);
  localparam logic [5:0] ON_LAST  = 6'(ON_TICKS - 1);
  localparam logic [5:0] OFF_LAST = 6'(OFF_TICKS - 1);
  localparam logic [5:0] A_BEEPS  = 6'(ALARM_BEEPS);

  state_t     state, state_nx;
  src_t       src_q, src_nx;
  logic [5:0] left_nx, phase, phase_nx, pend, pend_nx, base;
  logic       audio_nx, hour_ok, chime_req, unused_time;
  logic [4:0] hour_cnt;

  bcd_hour_count #(.TWELVE_HOUR(TWELVE_HOUR)) u_hour (
    .tens  (clock_time[23:20]),
    .ones  (clock_time[19:16]),
    .valid (hour_ok),
    .count (hour_cnt)
  );

  assign chime_req   = on_the_hour && hour_ok;
  assign busy        = (state != IDLE);
  assign src         = src_q;
  assign unused_time = ^clock_time[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      src_q      <= SRC_NONE;
      beeps_left <= '0;
      phase      <= '0;
      pend       <= '0;
      audio      <= 1'b0;
    end else begin
      state      <= state_nx;
      src_q      <= src_nx;
      beeps_left <= left_nx;
      phase      <= phase_nx;
      pend       <= pend_nx;
      audio      <= audio_nx;
    end
  end

  always_comb begin
    state_nx = state;
    src_nx   = src_q;
    left_nx  = beeps_left;
    phase_nx = phase;
    pend_nx  = pend;
    audio_nx = audio;
    base     = beeps_left;
    case (state)
      IDLE: begin
        if (on_alarm) begin
          state_nx = BEEP_ON;
          src_nx   = SRC_ALARM;
          left_nx  = A_BEEPS;
          phase_nx = '0;
          audio_nx = 1'b1;
          if (chime_req) pend_nx = {1'b0, hour_cnt};
        end else if (chime_req || pend != '0) begin
          // a fresh request supersedes a chime parked behind an alarm
          state_nx = BEEP_ON;
          src_nx   = SRC_CHIME;
          left_nx  = chime_req ? {1'b0, hour_cnt} : pend;
          phase_nx = '0;
          audio_nx = 1'b1;
          pend_nx  = '0;
        end
      end
      default: begin
        if (src_q == SRC_ALARM && chime_req) pend_nx = {1'b0, hour_cnt};
        if (src_q == SRC_ALARM && alarm_stop) begin
          state_nx = IDLE;
          src_nx   = SRC_NONE;
          left_nx  = '0;
          phase_nx = '0;
          audio_nx = 1'b0;
        end else if (src_q == SRC_CHIME && on_alarm) begin
          pend_nx  = beeps_left;
          state_nx = BEEP_ON;
          src_nx   = SRC_ALARM;
          left_nx  = A_BEEPS;
          phase_nx = '0;
          audio_nx = 1'b1;
        end else begin
          // on_alarm can only reach here while the alarm itself is playing
          base    = on_alarm ? A_BEEPS : beeps_left;
          left_nx = base;
          if (tick) begin
            if (state == BEEP_ON) begin
              if (phase == ON_LAST) begin
                left_nx  = base - 6'd1;
                audio_nx = 1'b0;
                phase_nx = '0;
                if (base == 6'd1) begin
                  state_nx = IDLE;
                  src_nx   = SRC_NONE;
                end else begin
                  state_nx = BEEP_OFF;
                end
              end else begin
                phase_nx = phase + 6'd1;
              end
            end else begin
              if (phase == OFF_LAST) begin
                state_nx = BEEP_ON;
                audio_nx = 1'b1;
                phase_nx = '0;
              end else begin
                phase_nx = phase + 6'd1;
              end
            end
          end
        end
      end
    endcase
  end
endmodule
